// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the fetch PC, drives a req/ready instruction memory and
// feeds IF/ID with redirect squash and a one-entry skid buffer. FETCH_PERF_EN adds perf counters.
module fetch_controller #(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'hD503201F
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetches,
    output logic [31:0]       perf_redirects,
    output logic [31:0]       perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DISCARD
    } fetch_state_t;

    fetch_state_t      r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [ADDR_W-1:0] r_req_addr, w_req_next;
    logic [ADDR_W-1:0] r_if_pc, w_if_pc_next;
    logic [ADDR_W-1:0] r_skid_pc, w_skid_pc_next;
    logic [31:0]       r_if_instr, w_if_instr_next;
    logic [31:0]       r_skid_instr, w_skid_instr_next;
    logic              r_if_valid, w_if_valid_next;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_req_plus4;

    // Targets are word aligned; the low two bits from the branch unit are ignored.
    assign w_target    = branch_target & ~ADDR_W'(3);
    assign w_req_plus4 = r_req_addr + ADDR_W'(4);

    assign imem_req  = (r_state == S_FETCH) || (r_state == S_DISCARD);
    assign imem_addr = r_req_addr;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_req_next        = r_req_addr;
        w_if_valid_next   = r_if_valid;
        w_if_instr_next   = r_if_instr;
        w_if_pc_next      = r_if_pc;
        w_skid_instr_next = r_skid_instr;
        w_skid_pc_next    = r_skid_pc;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
                w_req_next   = r_pc;
            end
            S_FETCH: begin
                if (branch_taken) begin
                    w_pc_next       = w_target;
                    w_if_valid_next = 1'b0;
                    w_if_instr_next = NOP_INSTR;
                    // A pending request must drain at its original address before redirecting.
                    if (imem_ready) begin
                        w_req_next = w_target;
                    end else begin
                        w_state_next = S_DISCARD;
                    end
                end else if (imem_ready && !stall) begin
                    w_if_instr_next = imem_rdata;
                    w_if_pc_next    = r_req_addr;
                    w_if_valid_next = 1'b1;
                    w_pc_next       = w_req_plus4;
                    w_req_next      = w_req_plus4;
                end else if (imem_ready) begin
                    w_skid_instr_next = imem_rdata;
                    w_skid_pc_next    = r_req_addr;
                    w_pc_next         = w_req_plus4;
                    w_state_next      = S_HOLD;
                end else if (!stall) begin
                    w_if_valid_next = 1'b0;
                    w_if_instr_next = NOP_INSTR;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    w_pc_next       = w_target;
                    w_req_next      = w_target;
                    w_if_valid_next = 1'b0;
                    w_if_instr_next = NOP_INSTR;
                    w_state_next    = S_FETCH;
                end else if (!stall) begin
                    w_if_instr_next = r_skid_instr;
                    w_if_pc_next    = r_skid_pc;
                    w_if_valid_next = 1'b1;
                    w_req_next      = r_pc;
                    w_state_next    = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (branch_taken) begin
                    w_pc_next = w_target;
                end
                if (imem_ready) begin
                    w_req_next   = branch_taken ? w_target : r_pc;
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_if_valid   <= 1'b0;
            r_if_instr   <= NOP_INSTR;
            r_if_pc      <= '0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_req_addr   <= w_req_next;
            r_if_valid   <= w_if_valid_next;
            r_if_instr   <= w_if_instr_next;
            r_if_pc      <= w_if_pc_next;
            r_skid_instr <= w_skid_instr_next;
            r_skid_pc    <= w_skid_pc_next;
        end
    end

`ifdef FETCH_PERF_EN
    logic        w_transfer;
    logic [31:0] r_perf_fetches, r_perf_redirects, r_perf_stall_cycles;

    // Discarded transfers still count as fetches since the memory did the work.
    assign w_transfer = imem_req && imem_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_perf_fetches      <= '0;
            r_perf_redirects    <= '0;
            r_perf_stall_cycles <= '0;
        end else begin
            if (w_transfer) begin
                r_perf_fetches <= r_perf_fetches + 32'd1;
            end
            if (branch_taken) begin
                r_perf_redirects <= r_perf_redirects + 32'd1;
            end
            if (r_state == S_HOLD) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            end
        end
    end

    assign perf_fetches      = r_perf_fetches;
    assign perf_redirects    = r_perf_redirects;
    assign perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the instruction-fetch stage of the pipelined ARMv8 core. It owns the fetch PC and issues requests to an instruction memory over a variable-latency req/ready handshake. It presents fetched instructions to the IF/ID boundary and applies redirects from the branch unit and stalls from the hazard unit. In-flight fetches are squashed on redirect, and an instruction that returns while decode is stalled is held in a one-entry skid buffer.

## Interface
- ADDR_W, 64, fetch address width
- RESET_PC, 64'h0, first fetch address after reset
- NOP_INSTR, 32'hD503201F, instruction word driven when if_valid=0
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- branch_taken  in  1  redirect request, valid for one cycle
- branch_target  in  ADDR_W  redirect address, sampled when branch_taken=1
- stall  in  1  decode stall from the hazard unit; IF/ID must hold
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address, stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  response strobe; transfer occurs when imem_req and imem_ready are both 1
- imem_rdata  in  32  instruction word, valid in the transfer cycle
- if_valid  out  1  IF/ID entry holds a live instruction
- if_instr  out  32  IF/ID instruction
- if_pc  out  ADDR_W  PC of if_instr

## Operation
- All outputs are registered except imem_req and imem_addr, which are decoded from the state and the req_addr register.
- **RESET** (reset=0 at an edge):
  - pc=RESET_PC, req_addr=RESET_PC, state=IDLE
  - if_valid=0, if_instr=NOP_INSTR, if_pc=0, skid buffer empty, imem_req=0
- **IDLE**: imem_req=0. Transitions to FETCH on the next cycle and loads req_addr=pc.
- **FETCH**: imem_req=1, imem_addr=req_addr. Cases are evaluated in priority order:
  1. **branch_taken**: pc=req_addr=branch_target, if_valid=0, if_instr=NOP_INSTR.
     - If imem_ready=1, the returned word is dropped and the state stays FETCH.
     - Otherwise the state goes to DISCARD and req_addr keeps the old address.
  2. **imem_ready & !stall**: if_instr=imem_rdata, if_pc=req_addr, if_valid=1, pc=req_addr=req_addr+4.
  3. **imem_ready & stall**: skid buffer = {imem_rdata, req_addr}, pc=req_addr+4, state goes to HOLD. IF/ID is unchanged.
  4. **!imem_ready & !stall**: if_valid=0 (bubble).
  5. **!imem_ready & stall**: IF/ID is unchanged.
- **HOLD**: imem_req=0.
  - branch_taken: the buffer is dropped, pc=req_addr=branch_target, if_valid=0, state goes to FETCH.
  - Otherwise, when stall=0: IF/ID is loaded from the buffer with if_valid=1, req_addr=pc, state goes to FETCH.
- **DISCARD**: imem_req=1, imem_addr is the old req_addr.
  - On imem_ready the data is dropped, req_addr=pc, state goes to FETCH.
  - A further branch_taken updates pc to the newest target and the state stays DISCARD.
  - if_valid stays 0.
- **Priority rules**:
  - branch_taken overrides stall, because the stalled younger instruction is being squashed.
  - Reset overrides everything.
- **Arithmetic**: PC increment is modulo 2^ADDR_W and wraps without a flag. branch_target[1:0] is forced to 0.
- **Reset mid-transfer**: the outstanding request is abandoned. The memory tolerates imem_req falling without ready.

## Timing
- **Zero-wait memory** (imem_ready=1 in the request cycle): one instruction per cycle. if_valid rises 2 cycles after reset deasserts.
- **Instruction latency**: imem_rdata appears on if_instr at the edge ending its transfer cycle.
- **Branch penalty**: branch_taken in cycle t gives imem_addr=branch_target in cycle t+1 when no fetch is pending unacknowledged; otherwise it is delayed by the drain time. if_valid=0 in cycle t+1.
- **HOLD release**: stall falls in cycle t, if_valid=1 with the buffered word in t+1, the next fetch is issued in t+1.
- imem_addr never changes while imem_req=1 and imem_ready=0.

## Configuration
- **FETCH_PERF_EN** defined: three extra outputs, all 32 bits, cleared on reset, wrapping at 2^32:
  - perf_fetches: counts accepted transfers, including discarded ones
  - perf_redirects: counts cycles with branch_taken=1
  - perf_stall_cycles: counts cycles in HOLD
- FETCH_PERF_EN undefined: these ports and their counters do not exist. Functional behaviour is identical in both builds.

## Test plan
- **Reset and streaming**: reset low 3 cycles then high, imem_ready tied 1, memory word = address.
  - if_pc runs 0,4,8,… one per cycle, if_valid=1 from cycle 2.
- **Wait states**: ready asserted every 3rd request cycle.
  - imem_addr is stable across waits; bubbles with if_valid=0 appear between instructions; no PC is skipped.
- **Stall into HOLD**: stall=1 for 4 cycles while PC 0x10 returns.
  - IF/ID holds 0x0C; imem_req=0 during HOLD; 0x10 appears the cycle after stall falls, then 0x14 follows.
- **Redirect during wait**: branch_taken with target 0x400 while 0x20 is pending, ready after 2 cycles.
  - The 0x20 data is dropped, the next imem_addr=0x400, and 0x20 never has if_valid=1.
- **Branch with stall**: branch_taken=1 and stall=1 in the same cycle with the state in HOLD.
  - if_valid=0 next cycle, the buffer is dropped, fetch resumes at the target.
- **Wrap and reset mid-transfer**: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC.
  - The second fetch is at 0; a reset pulse during a pending request returns the block to IDLE with if_valid=0.
